mult_rr_arbiter: RTL and testbench
==================================

Name: mult_rr_arbiter

Overview:
- Round-robin scheduler that shares one bus-based multiplier unit (bgn/ibus/obus/fin interface) between N_REQ requesters.
- Each requester gets valid/ready request and response channels.
- Sequences operand transfer onto the multiplier ibus and waits for fin.
- Captures the two result words from the multiplier obus and returns the 2*WIDTH-bit signed product to the winning requester.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 32, operand width; must equal the multiplier WIDTH.
- TIMEOUT, 64, watchdog limit in cycles for fin (used only with the optional feature).

Ports:
- clk  input  1  clock.
- rst_b  input  1  asynchronous reset, active-low.
- req_valid  input  N_REQ  per-requester request valid.
- req_ready  output  N_REQ  per-requester request accept (one-hot or zero).
- req_x  input  N_REQ*WIDTH  multiplicand per requester; slice i is [i*WIDTH +: WIDTH].
- req_y  input  N_REQ*WIDTH  multiplier per requester; same slicing.
- rsp_valid  output  N_REQ  per-requester response valid (one-hot or zero).
- rsp_ready  input  N_REQ  per-requester response accept.
- rsp_hi  output  WIDTH  product high word, shared by all requesters.
- rsp_lo  output  WIDTH  product low word, shared by all requesters.
- rsp_err  output  1  timeout flag, qualified by rsp_valid.
- m_bgn  output  1  start pulse to the multiplier.
- m_ibus  output  WIDTH  operand bus to the multiplier.
- m_obus  input  WIDTH  result bus from the multiplier.
- m_fin  input  1  multiplier done.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, rr pointer 0, captured result registers 0.
- FSM states: IDLE, LDX0, LDX1, LDY0, LDY1, WAIT, RESP.
- IDLE:
  - Grant the first requester with req_valid=1, searching upward from ptr and wrapping at N_REQ-1 to 0.
  - In the grant cycle req_ready[g]=1 for exactly one cycle (the handshake), and {x,y} are latched into internal registers.
  - Next state is LDX0; grant index g is stored.
  - If no request is valid, stay in IDLE.
- LDX0: m_bgn=1, m_ibus=x.
- LDX1: m_bgn=0, m_ibus=x.
- LDY0: m_ibus=y.
- LDY1: m_ibus=y.
- WAIT:
  - m_ibus=0.
  - Every cycle, register m_obus into prev_obus.
  - When m_fin=1: rsp_hi<=prev_obus (multiplier drives A in the cycle before fin) and rsp_lo<=m_obus (Q in the fin cycle); go to RESP.
- m_bgn is a single-cycle pulse; it is never asserted outside LDX0.
- m_ibus is 0 in IDLE, WAIT and RESP.
- RESP:
  - rsp_valid[g]=1; rsp_hi, rsp_lo and rsp_err are held stable until rsp_ready[g]=1.
  - On that handshake: ptr<=(g+1) mod N_REQ, then IDLE.
  - rsp_ready on non-granted lines is ignored.
- Latency, request handshake to rsp_valid: 4 load cycles + multiplier compute cycles + 1.
- No new grant is issued while busy; only one operation is ever outstanding.
- req_valid of other requesters may rise or fall during an operation without effect.
- m_fin seen outside WAIT is ignored.
- Fairness: after serving g, requester g has lowest priority. With all requesters valid, service order is 0,1,2,...,N_REQ-1,0.
- Product is signed two's complement; rsp_hi:rsp_lo forwards the multiplier output unmodified.
- Asynchronous reset mid-operation returns to IDLE, clears rsp_valid, m_bgn and m_ibus immediately, and resets ptr to 0. The in-flight request is dropped and is not re-issued.
- ptr wrap: ptr=N_REQ-1 advances to 0.

Optional Feature:
- Macro: MULT_ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter (width $clog2(TIMEOUT+1)) is cleared on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT without m_fin: go to RESP with rsp_err=1, rsp_hi=0, rsp_lo=0.
  - m_fin in the same cycle as reaching TIMEOUT takes precedence, giving a normal result with rsp_err=0.
- Not defined: no counter; WAIT persists until m_fin; rsp_err is tied to 0.

Test Plan:
- Single request: req 0 with x=101, y=63 -> m_bgn one-cycle pulse; m_ibus=101 for 2 cycles then 63 for 2 cycles; rsp_valid[0] with rsp_hi=0, rsp_lo=0x000018DB (6363).
- Signed operands: req 2 with x=-3 (0xFFFFFFFD), y=5 -> rsp_hi=0xFFFFFFFF, rsp_lo=0xFFFFFFF1.
- Round-robin: all 4 req_valid held high with distinct operands, rsp_ready always 1 -> grants in order 0,1,2,3,0; no requester is granted twice before the others are served.
- Response backpressure: hold rsp_ready[1]=0 for 10 cycles after rsp_valid[1] -> outputs stable, no new req_ready pulse; release -> IDLE next cycle, ptr=2.
- Reset mid-WAIT: assert rst_b=0 during WAIT -> all outputs 0 asynchronously; after release, a new request to req 3 completes correctly with grant from ptr 0.
- With MULT_ARB_TIMEOUT_EN and TIMEOUT=64: multiplier model never asserts m_fin -> rsp_valid after exactly 64 WAIT cycles with rsp_err=1, rsp_hi=rsp_lo=0.

Source files
------------

// File: rtl/mult_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// mult_rr_arbiter_if
// Bundles the requester channels and the shared multiplier bus seen by
// mult_rr_arbiter.
//   req_valid/req_ready/req_x/req_y : per-requester operand channel
//   rsp_valid/rsp_ready/rsp_hi/rsp_lo/rsp_err : per-requester result channel
//   m_bgn/m_ibus/m_obus/m_fin : bus to the shared multiplier unit
// Modports:
//   slave  - the arbiter
//   master - the environment (requesters plus multiplier)
// ---------------------------------------------------------------------------
interface mult_rr_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 32
);
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*WIDTH-1:0] req_x;
    logic [N_REQ*WIDTH-1:0] req_y;
    logic [N_REQ-1:0]       rsp_valid;
    logic [N_REQ-1:0]       rsp_ready;
    logic [WIDTH-1:0]       rsp_hi;
    logic [WIDTH-1:0]       rsp_lo;
    logic                   rsp_err;
    logic                   m_bgn;
    logic [WIDTH-1:0]       m_ibus;
    logic [WIDTH-1:0]       m_obus;
    logic                   m_fin;

    modport slave (
        input  req_valid, req_x, req_y, rsp_ready, m_obus, m_fin,
        output req_ready, rsp_valid, rsp_hi, rsp_lo, rsp_err, m_bgn, m_ibus
    );

    modport master (
        output req_valid, req_x, req_y, rsp_ready, m_obus, m_fin,
        input  req_ready, rsp_valid, rsp_hi, rsp_lo, rsp_err, m_bgn, m_ibus
    );
endinterface

// File: rtl/mult_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mult_rr_arbiter
// Round-robin scheduler sharing one bus-based multiplier between N_REQ
// requesters. Operands are shifted onto m_ibus (x twice, y twice, with m_bgn
// on the first x cycle), then the two result words are collected from m_obus
// (high word the cycle before m_fin, low word in the m_fin cycle) and
// returned to the granted requester.
// Ports:
//   clk   - clock
//   rst_b - asynchronous reset, active-low
//   bus   - mult_rr_arbiter_if.slave (request/response channels, multiplier bus)
// Optional build macro MULT_ARB_TIMEOUT_EN: adds a watchdog on m_fin that
// returns rsp_err=1 with a zero product after TIMEOUT WAIT cycles.
//
// state | meaning
// IDLE  | pick next requester from ptr, handshake and latch operands
// LDX0  | m_bgn pulse, x on m_ibus
// LDX1  | x on m_ibus
// LDY0  | y on m_ibus
// LDY1  | y on m_ibus
// WAIT  | track m_obus, wait for m_fin (or watchdog)
// RESP  | present result to granted requester until rsp_ready
// ---------------------------------------------------------------------------
module mult_rr_arbiter #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 64
) (
    input logic              clk,
    input logic              rst_b,
    mult_rr_arbiter_if.slave bus
);
    localparam int IW = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
        $error("mult_rr_arbiter: N_REQ must be in 2..8");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("mult_rr_arbiter: TIMEOUT must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LDX0,
        S_LDX1,
        S_LDY0,
        S_LDY1,
        S_WAIT,
        S_RESP
    } state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [IW-1:0]    gnt_q, gnt_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             err_q, err_d;

    logic             found;
    logic [IW-1:0]    pick;
    logic             expired;

    // First valid requester at or above ptr, wrapping past N_REQ-1.
    always_comb begin
        int j;
        j     = 0;
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            j = int'(ptr_q) + i;
            if (j >= N_REQ) j = j - N_REQ;
            if (!found && bus.req_valid[j]) begin
                found = 1'b1;
                pick  = IW'(j);
            end
        end
    end

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int              CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);
    logic [CW-1:0] cnt_q, cnt_d;

    // Cleared while entering WAIT; the last WAIT cycle is the one where
    // the count is about to reach TIMEOUT.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_LDY1)      cnt_d = '0;
        else if (state_q == S_WAIT) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign expired = (cnt_q == CNT_LAST);
`else
    assign expired = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        x_d     = x_q;
        y_d     = y_q;
        prev_d  = prev_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        err_d   = err_q;

        bus.req_ready = '0;
        bus.rsp_valid = '0;
        bus.m_bgn     = 1'b0;
        bus.m_ibus    = '0;

        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    bus.req_ready[pick] = 1'b1;
                    gnt_d   = pick;
                    x_d     = bus.req_x[int'(pick)*WIDTH +: WIDTH];
                    y_d     = bus.req_y[int'(pick)*WIDTH +: WIDTH];
                    state_d = S_LDX0;
                end
            end
            S_LDX0: begin
                bus.m_bgn  = 1'b1;
                bus.m_ibus = x_q;
                state_d    = S_LDX1;
            end
            S_LDX1: begin
                bus.m_ibus = x_q;
                state_d    = S_LDY0;
            end
            S_LDY0: begin
                bus.m_ibus = y_q;
                state_d    = S_LDY1;
            end
            S_LDY1: begin
                bus.m_ibus = y_q;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                // Multiplier presents the high word one cycle ahead of fin.
                prev_d = bus.m_obus;
                if (bus.m_fin) begin
                    hi_d    = prev_q;
                    lo_d    = bus.m_obus;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (expired) begin
                    hi_d    = '0;
                    lo_d    = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                bus.rsp_valid[gnt_q] = 1'b1;
                if (bus.rsp_ready[gnt_q]) begin
                    ptr_d   = (gnt_q == IW'(N_REQ - 1)) ? '0 : gnt_q + 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            prev_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            prev_q  <= prev_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            err_q   <= err_d;
        end
    end

    assign bus.rsp_hi  = hi_q;
    assign bus.rsp_lo  = lo_q;
    assign bus.rsp_err = err_q;
endmodule

// File: tb/tb_mult_rr_arbiter.sv
module tb_mult_rr_arbiter;
    localparam int N = 4;
    localparam int W = 32;

    logic clk   = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    mult_rr_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus_if ();

    mult_rr_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT(64)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus_if)
    );

    int checks   = 0;
    int failures = 0;
    bit no_fin   = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Multiplier model: x on the m_bgn cycle, y two cycles later,
    // high word in WAIT cycle 2, low word with fin in WAIT cycle 3.
    initial begin : mult_model
        int                    k;
        bit                    busy;
        logic [W-1:0]          mx, my;
        logic signed [2*W-1:0] sx, sy, p;
        k = 0; busy = 1'b0; mx = '0; my = '0;
        bus_if.m_fin  = 1'b0;
        bus_if.m_obus = '0;
        forever begin
            @(negedge clk);
            if (!rst_b) begin
                busy = 1'b0; bus_if.m_fin = 1'b0; bus_if.m_obus = '0;
            end else if (!busy) begin
                bus_if.m_fin = 1'b0; bus_if.m_obus = '0;
                if (bus_if.m_bgn) begin busy = 1'b1; k = 0; mx = bus_if.m_ibus; end
            end else begin
                k++;
                if (k == 2) my = bus_if.m_ibus;
                sx = {{W{mx[W-1]}}, mx};
                sy = {{W{my[W-1]}}, my};
                p  = sx * sy;
                if (bus_if.rsp_valid != '0) begin
                    busy = 1'b0; bus_if.m_fin = 1'b0; bus_if.m_obus = '0;
                end else if (!no_fin && k == 6) begin
                    bus_if.m_obus = p[2*W-1:W];
                end else if (!no_fin && k == 7) begin
                    bus_if.m_obus = p[W-1:0]; bus_if.m_fin = 1'b1;
                end else begin
                    bus_if.m_obus = '0; bus_if.m_fin = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic set_req(input int i, input logic [W-1:0] x, input logic [W-1:0] y);
        bus_if.req_x[i*W +: W] = x;
        bus_if.req_y[i*W +: W] = y;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_rsp(inout int cyc);
        while (bus_if.rsp_valid == '0 && cyc < 300) begin tick(); cyc++; end
    endtask

    task automatic wait_grant();
        int c;
        c = 0;
        #1;
        while (bus_if.req_ready == '0 && c < 100) begin tick(); c++; end
    endtask

    task automatic run_op(input string tag, input int i, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic [W-1:0] eh, input logic [W-1:0] el);
        int         cyc;
        logic [N-1:0] g;
        g = '0; g[i] = 1'b1;
        set_req(i, x, y);
        bus_if.req_valid = g;
        #1;
        chk({tag, "_gnt"}, 64'(bus_if.req_ready), 64'(g));
        tick();
        bus_if.req_valid = '0;
        cyc = 1;
        wait_rsp(cyc);
        chk({tag, "_latency"}, 64'(cyc), 64'd9);
        chk({tag, "_rsp_valid"}, 64'(bus_if.rsp_valid), 64'(g));
        chk({tag, "_hi"}, 64'(bus_if.rsp_hi), 64'(eh));
        chk({tag, "_lo"}, 64'(bus_if.rsp_lo), 64'(el));
        chk({tag, "_err"}, 64'(bus_if.rsp_err), 64'd0);
        tick();
    endtask

    logic [W-1:0] rr_lo [5];

    initial begin : stim
        int cyc;
        bus_if.req_valid = '0;
        bus_if.req_x     = '0;
        bus_if.req_y     = '0;
        bus_if.rsp_ready = '1;
        rst_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 64'(bus_if.req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(bus_if.rsp_valid), 64'd0);
        chk("rst_m_bgn",     64'(bus_if.m_bgn),     64'd0);
        chk("rst_m_ibus",    64'(bus_if.m_ibus),    64'd0);
        chk("rst_rsp_hi",    64'(bus_if.rsp_hi),    64'd0);
        chk("rst_rsp_lo",    64'(bus_if.rsp_lo),    64'd0);
        chk("rst_rsp_err",   64'(bus_if.rsp_err),   64'd0);
        rst_b = 1'b1;
        tick();
        chk("idle_m_bgn", 64'(bus_if.m_bgn), 64'd0);

        // Single request with full bus trace
        set_req(0, 32'd101, 32'd63);
        bus_if.req_valid = 4'b0001;
        #1;
        chk("t1_gnt", 64'(bus_if.req_ready), 64'h1);
        tick();
        bus_if.req_valid = '0;
        chk("t1_ldx0_bgn",  64'(bus_if.m_bgn),     64'd1);
        chk("t1_ldx0_ibus", 64'(bus_if.m_ibus),    64'd101);
        chk("t1_ldx0_rdy",  64'(bus_if.req_ready), 64'd0);
        tick();
        chk("t1_ldx1_bgn",  64'(bus_if.m_bgn),  64'd0);
        chk("t1_ldx1_ibus", 64'(bus_if.m_ibus), 64'd101);
        tick();
        chk("t1_ldy0_ibus", 64'(bus_if.m_ibus), 64'd63);
        tick();
        chk("t1_ldy1_ibus", 64'(bus_if.m_ibus), 64'd63);
        tick();
        chk("t1_wait_ibus", 64'(bus_if.m_ibus), 64'd0);
        chk("t1_wait_bgn",  64'(bus_if.m_bgn),  64'd0);
        cyc = 5;
        wait_rsp(cyc);
        chk("t1_latency",   64'(cyc),              64'd9);
        chk("t1_rsp_valid", 64'(bus_if.rsp_valid), 64'h1);
        chk("t1_hi",        64'(bus_if.rsp_hi),    64'h0);
        chk("t1_lo",        64'(bus_if.rsp_lo),    64'h0000_18DB);
        chk("t1_err",       64'(bus_if.rsp_err),   64'd0);
        tick();
        chk("t1_rsp_done",  64'(bus_if.rsp_valid), 64'd0);

        // Signed operands
        run_op("signed", 2, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);

        // Round-robin from a fresh pointer
        rst_b = 1'b0;
        tick();
        rst_b = 1'b1;
        tick();
        for (int i = 0; i < N; i++) set_req(i, W'(i + 2), W'(10 * (i + 1)));
        rr_lo[0] = 32'd20; rr_lo[1] = 32'd60; rr_lo[2] = 32'd120;
        rr_lo[3] = 32'd200; rr_lo[4] = 32'd20;
        bus_if.req_valid = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            wait_grant();
            chk($sformatf("rr_gnt%0d", n), 64'(bus_if.req_ready), 64'(1 << (n % N)));
            if (n == 4) begin
                tick();
                bus_if.req_valid = '0;
            end
            cyc = 0;
            wait_rsp(cyc);
            chk($sformatf("rr_rsp%0d", n), 64'(bus_if.rsp_valid), 64'(1 << (n % N)));
            chk($sformatf("rr_lo%0d", n),  64'(bus_if.rsp_lo),    64'(rr_lo[n]));
            tick();
        end

        // Response backpressure on requester 1 (ptr now 1)
        set_req(0, 32'd3, 32'd3);
        set_req(1, 32'd7, 32'd9);
        set_req(2, 32'd6, 32'd7);
        bus_if.rsp_ready = 4'b1101;
        bus_if.req_valid = 4'b0111;
        wait_grant();
        chk("bp_gnt", 64'(bus_if.req_ready), 64'h2);
        tick();
        cyc = 1;
        wait_rsp(cyc);
        chk("bp_rsp_valid", 64'(bus_if.rsp_valid), 64'h2);
        chk("bp_lo",        64'(bus_if.rsp_lo),    64'd63);
        for (int c = 0; c < 10; c++) begin
            tick();
            chk($sformatf("bp_hold_valid%0d", c), 64'(bus_if.rsp_valid), 64'h2);
            chk($sformatf("bp_hold_lo%0d", c),    64'(bus_if.rsp_lo),    64'd63);
            chk($sformatf("bp_hold_hi%0d", c),    64'(bus_if.rsp_hi),    64'd0);
            chk($sformatf("bp_hold_rdy%0d", c),   64'(bus_if.req_ready), 64'd0);
        end
        bus_if.rsp_ready = '1;
        tick();
        chk("bp_release_valid", 64'(bus_if.rsp_valid), 64'd0);
        chk("bp_next_gnt",      64'(bus_if.req_ready), 64'h4);
        tick();
        bus_if.req_valid = '0;
        cyc = 1;
        wait_rsp(cyc);
        chk("bp2_rsp_valid", 64'(bus_if.rsp_valid), 64'h4);
        chk("bp2_lo",        64'(bus_if.rsp_lo),    64'd42);
        tick();

        // Reset in the middle of WAIT
        set_req(1, 32'd11, 32'd13);
        bus_if.req_valid = 4'b0010;
        wait_grant();
        chk("rw_gnt", 64'(bus_if.req_ready), 64'h2);
        tick();
        bus_if.req_valid = '0;
        repeat (5) tick();
        #2;
        rst_b = 1'b0;
        #1;
        chk("rw_rsp_valid", 64'(bus_if.rsp_valid), 64'd0);
        chk("rw_m_bgn",     64'(bus_if.m_bgn),     64'd0);
        chk("rw_m_ibus",    64'(bus_if.m_ibus),    64'd0);
        chk("rw_rsp_lo",    64'(bus_if.rsp_lo),    64'd0);
        chk("rw_rsp_hi",    64'(bus_if.rsp_hi),    64'd0);
        chk("rw_rsp_err",   64'(bus_if.rsp_err),   64'd0);
        @(negedge clk);
        @(negedge clk);
        #1;
        rst_b = 1'b1;
        tick();
        chk("rw_idle_rdy", 64'(bus_if.req_ready), 64'd0);
        chk("rw_idle_bgn", 64'(bus_if.m_bgn),     64'd0);
        run_op("post_rst", 3, 32'd1000, 32'hFFFF_FC18, 32'hFFFF_FFFF, 32'hFFF0_BDC0);
        tick();
        chk("post_rst_idle_bgn", 64'(bus_if.m_bgn), 64'd0);

`ifdef MULT_ARB_TIMEOUT_EN
        // Watchdog: multiplier never finishes
        no_fin = 1'b1;
        set_req(0, 32'd5, 32'd5);
        bus_if.req_valid = 4'b0001;
        wait_grant();
        chk("to_gnt", 64'(bus_if.req_ready), 64'h1);
        tick();
        bus_if.req_valid = '0;
        cyc = 1;
        wait_rsp(cyc);
        chk("to_latency",   64'(cyc),              64'd69);
        chk("to_rsp_valid", 64'(bus_if.rsp_valid), 64'h1);
        chk("to_err",       64'(bus_if.rsp_err),   64'd1);
        chk("to_hi",        64'(bus_if.rsp_hi),    64'd0);
        chk("to_lo",        64'(bus_if.rsp_lo),    64'd0);
        tick();
        no_fin = 1'b0;
        run_op("after_to", 1, 32'd12, 32'd12, 32'd0, 32'd144);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
